// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: FSM encoding and
// default debounce / browse-address limits.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } run_state_e;

  localparam int DEF_DB_LIMIT = 1000000;
  localparam int DEF_DB_W     = 20;
  localparam int DEF_ADDR_MAX = 255;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge pulse for one raw
// board input. Raw-to-level latency is 2+DB_LIMIT cycles; pulse is one cycle.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_LIMIT = DEF_DB_LIMIT,
  parameter int DB_W     = DEF_DB_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DB_LIMIT - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_dly_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing the CPU clock enable, plus the
// debug browse address and executed-cycle counter.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_LIMIT = DEF_DB_LIMIT,
  parameter int DB_W     = DEF_DB_W,
  parameter int ADDR_MAX = DEF_ADDR_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cont,
  input  logic        step,
  input  logic        mem,
  input  logic        inc,
  input  logic        dec,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_ce,
  output logic [31:0] addr,
  output logic        view_mem,
  output logic [1:0]  state_o,
  output logic        bp_hit,
  output logic [31:0] cycle_cnt
);

  localparam logic [31:0] AMAX = 32'(ADDR_MAX);

  logic [4:0] raw_in, db_level, db_rise;
  logic       cont_db, step_p, inc_p, dec_p;
  logic [5:0] db_unused;

  assign raw_in = {dec, inc, mem, step, cont};

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(
      .DB_LIMIT(DB_LIMIT),
      .DB_W    (DB_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_in[i]),
      .level_o(db_level[i]),
      .rise_o (db_rise[i])
    );
  end

  assign cont_db  = db_level[0];
  assign step_p   = db_rise[1];
  assign view_mem = db_level[2];
  assign inc_p    = db_rise[3];
  assign dec_p    = db_rise[4];
  // Levels of the button inputs and edges of the switches have no consumer.
  assign db_unused = {db_level[4], db_level[3], db_level[1], db_rise[2], db_rise[0], 1'b0};

  run_state_e  state_q, state_d;
  logic        skip_q, skip_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cpu_ce  = 1'b0;
    case (state_q)
      PAUSE: begin
        if (cont_db) begin
          state_d = RUN;
          skip_d  = 1'b1;
        end else if (step_p) begin
          state_d = STEP;
        end
      end
      STEP: begin
        cpu_ce  = 1'b1;
        state_d = PAUSE;
      end
      RUN: begin
        // skip lets the CPU leave a PC it was halted on when resuming.
        skip_d = 1'b0;
        if (!cont_db) begin
          state_d = PAUSE;
        end else if (bp_en && (pc == bp_addr) && !skip_q) begin
          state_d = BREAK;
        end else begin
          cpu_ce = 1'b1;
        end
      end
      BREAK: begin
        cpu_ce = step_p;
        if (!cont_db) state_d = PAUSE;
      end
      default: state_d = PAUSE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (inc_p && !dec_p) begin
      addr_d = (addr_q == AMAX) ? 32'd0 : addr_q + 32'd1;
    end else if (dec_p && !inc_p) begin
      addr_d = (addr_q == 32'd0) ? AMAX : addr_q - 32'd1;
    end
    cnt_d = cpu_ce ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAUSE;
      skip_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign bp_hit    = (state_q == BREAK);
  assign addr      = addr_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step sequencer sitting between the board buttons/switches and the pipeline CPU. It conditions the raw inputs and issues a per-cycle CPU clock enable in continuous, single-step or breakpoint-halted modes. It also maintains the debug browse address driven to the DM/RF show ports, and a count of executed CPU cycles. The CPU is clocked by the system clock and gated only by cpu_ce; the block never derives a clock.

Parameters:
DB_LIMIT, 1000000, cycles an input must be stable before its debounced level changes (10 ms at 100 MHz); benches use 4
DB_W, 20, debounce counter width; must hold DB_LIMIT
ADDR_MAX, 255, highest browse address; the browse address wraps at this value

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
cont  in  1  raw run switch; level-sensitive
step  in  1  raw single-step button
mem  in  1  raw view-select switch: 1 = DM view, 0 = RF view
inc  in  1  raw browse-address increment button
dec  in  1  raw browse-address decrement button
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  current CPU PC (Show_PC)
cpu_ce  out  1  CPU clock enable; CPU state advances on a clk edge only when this is 1
addr  out  32  browse address, zero-extended, range 0..ADDR_MAX
view_mem  out  1  debounced mem level
state_o  out  2  current FSM state
bp_hit  out  1  1 while in BREAK
cycle_cnt  out  32  number of cycles with cpu_ce=1; wraps

Behaviour:
- Reset: FSM=PAUSE; cpu_ce=0, addr=0, view_mem=0, bp_hit=0, cycle_cnt=0. All debounced levels and counters are 0, and skip=0. Reset asserted mid-run takes effect at the next edge, overriding all other events.
- Input conditioning, per input: 2-flop synchroniser, then debouncer. The debouncer counter clears whenever the synchronised input equals the debounced level; otherwise it increments. When it reaches DB_LIMIT-1, the debounced level toggles and the counter clears. A rising edge of the debounced level gives a 1-cycle pulse (step_p, inc_p, dec_p). Input-to-debounced latency is 2+DB_LIMIT cycles.
- FSM states, encoded 2 bits: PAUSE=0, RUN=1, STEP=2, BREAK=3.
  - PAUSE: cpu_ce=0. If cont_db=1, go to RUN and set skip=1. Else if step_p=1, go to STEP.
  - STEP: cpu_ce=1 for exactly one cycle, then go to PAUSE. The breakpoint is ignored.
  - RUN: if cont_db=0, go to PAUSE with cpu_ce=0 that cycle. Else if bp_en=1, pc==bp_addr and skip=0, go to BREAK with cpu_ce=0 that cycle. Otherwise cpu_ce=1. skip clears after the first RUN cycle. step_p is ignored in RUN.
  - BREAK: cpu_ce=0, bp_hit=1. step_p gives cpu_ce=1 for one cycle and the state stays BREAK. If cont_db=0, go to PAUSE. RUN is not re-entered until cont goes low and then high again.
- cpu_ce is combinational from the registered state, skip, pc, bp_addr, bp_en and cont_db. No state leaves PAUSE without cont_db or step_p.
- Browse address:
  - inc_p alone: addr+1, wrapping ADDR_MAX→0.
  - dec_p alone: addr-1, wrapping 0→ADDR_MAX.
  - inc_p and dec_p in the same cycle: no change.
  - Updates take effect the cycle after the pulse and are independent of FSM state.
- cycle_cnt increments by 1 on every edge where cpu_ce=1, and wraps at 2^32.
- view_mem equals the debounced mem level.

Decomposition:
- Shared package cpu_ctrl_pkg: FSM state constants PAUSE/RUN/STEP/BREAK, default DB_LIMIT, and ADDR_MAX.
- One sub-module, btn_debounce (synchroniser + debouncer + rising-edge pulse, parameter DB_LIMIT), instantiated five times.
- FSM, address counter and cycle counter stay in cpu_run_ctrl.

Test Plan:
- Reset/idle: DB_LIMIT=4; hold rst 2 cycles, then all inputs 0 for 20 cycles → cpu_ce=0, addr=0, state_o=0, cycle_cnt=0 throughout.
- Step: pulse step high 10 cycles → exactly one cpu_ce=1 cycle, 7 cycles after the rising input; cycle_cnt=1; state returns to 0. A 2-cycle glitch on step → no cpu_ce.
- Run/stop: cont high → state_o=1 and cpu_ce=1 every cycle. Drop cont after 50 enabled cycles → cpu_ce=0 within 7 cycles; cycle_cnt equals the count of cpu_ce=1 cycles.
- Breakpoint: bp_en=1, bp_addr=0x0C, pc driven by a model that adds 4 per cpu_ce → halts with pc=0x0C, cpu_ce=0, bp_hit=1, state_o=3. Step → one cpu_ce, pc=0x10, still BREAK. Cycle cont → RUN with no immediate re-halt at the same PC (skip).
- Address wrap: dec from reset → addr=255. inc → addr=0. inc ×3 → 3. inc and dec in the same cycle → unchanged.
- Reset mid-run: assert rst while in RUN with addr=5 → next edge: state 0, cpu_ce=0, addr=0, cycle_cnt=0, debounced levels 0.
